// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared types and constants for the DMG OAM DMA sequencer.
//   dma_state_t   : sequencer states (IDLE, START, XFER)
//   DMA_REG_ADDR  : CPU address of the DMA source register
//   OAM_LEN       : bytes copied per transfer
//   ECHO_MASK/BASE: echo-RAM folding of the source page
//   src_page()    : maps a written register value to the page actually read
// -----------------------------------------------------------------------------
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam int          OAM_LEN      = 160;
  localparam logic [7:0]  ECHO_MASK    = 8'hDF;
  localparam logic [7:0]  ECHO_BASE    = 8'hE0;

  // Pages E0..FF alias the work RAM 8 KiB below, so bit 5 is dropped there.
  function automatic logic [7:0] src_page(input logic [7:0] value);
    return (value >= ECHO_BASE) ? (value & ECHO_MASK) : value;
  endfunction

endpackage

// File: rtl/dma_idx_counter.sv
// -----------------------------------------------------------------------------
// dma_idx_counter
// 9-bit byte index for the OAM DMA. Loads 0, increments or holds on each
// enabled edge; terminal count flags the last byte of a transfer.
//   clk, reset  : clock, synchronous active-high reset
//   en_i        : advance enable (M-cycle strobe)
//   load0_i     : restart the index at 0 (takes priority over inc_i)
//   inc_i       : step to the next byte
//   idx_nxt_o   : low byte of the index the counter will hold after this edge
//   tc_o        : current index is LEN-1
// -----------------------------------------------------------------------------
module dma_idx_counter
  import dma_pkg::*;
#(
  parameter int LEN = OAM_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       load0_i,
  input  logic       inc_i,
  output logic [7:0] idx_nxt_o,
  output logic       tc_o
);

  logic [8:0] idx_q;
  logic [8:0] idx_d;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx_d = idx_q;
    if (load0_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + 9'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else if (en_i) begin
      idx_q <= idx_d;
    end
  end

  assign idx_nxt_o = idx_d[7:0];
  assign tc_o      = (idx_q == 9'(LEN - 1));

endmodule

// File: rtl/oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl
// Sequencer for the DMG OAM DMA engine. A CPU write to the DMA register
// starts a copy of LEN bytes from {src_hi, 8'h00} into OAM, one byte per
// M-cycle, with a one-cycle read->write pipeline. All outputs are registered.
//   clk, reset     : clock, synchronous active-high reset (ignores mcyc_en)
//   mcyc_en        : M-cycle strobe; state only advances when high
//   cpu_wr/addr/wdata : CPU write port (qualified by mcyc_en)
//   rd_data        : bus data for the DMA read issued this M-cycle
//   ff46_rdata     : last value written to the DMA register
//   dma_rd_en/addr : DMA bus read this M-cycle
//   oam_wr_en/addr/data : OAM write this M-cycle
//   dma_busy       : transfer pending or active
//   cpu_bus_block  : CPU external-bus accesses must be ignored
// -----------------------------------------------------------------------------
module oam_dma_ctrl
  import dma_pkg::*;
#(
  parameter int          LEN         = OAM_LEN,
  parameter int          START_DELAY = 1,
  parameter logic [15:0] REG_ADDR    = DMA_REG_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mcyc_en,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  rd_data,
  output logic [7:0]  ff46_rdata,
  output logic        dma_rd_en,
  output logic [15:0] dma_rd_addr,
  output logic        oam_wr_en,
  output logic [7:0]  oam_wr_addr,
  output logic [7:0]  oam_wr_data,
  output logic        dma_busy,
  output logic        cpu_bus_block
);

  localparam int DW = $clog2(START_DELAY + 1);

  dma_state_t  state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [7:0]  pend_src_q, pend_src_d;   // page latched by the last register write
  logic [7:0]  src_q, src_d;             // page the running transfer reads from
  logic        blk_hold_q, blk_hold_d;   // START entered while the bus was owned
  logic [7:0]  ff46_q, ff46_d;

  logic        rd_en_q, rd_en_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        blk_q, blk_d;

  logic        wr_hit;
  logic        old_more;
  logic        idx_load0;
  logic        idx_inc;
  logic [7:0]  idx_nxt;
  logic        idx_tc;

  dma_idx_counter #(
    .LEN (LEN)
  ) u_idx (
    .clk       (clk),
    .reset     (reset),
    .en_i      (mcyc_en),
    .load0_i   (idx_load0),
    .inc_i     (idx_inc),
    .idx_nxt_o (idx_nxt),
    .tc_o      (idx_tc)
  );

  assign wr_hit   = cpu_wr && (cpu_addr == REG_ADDR);
  // A read is issued this cycle and it is not the last byte: the running
  // transfer continues next cycle, even inside a restart's START window.
  assign old_more = rd_en_q && !idx_tc;

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    pend_src_d = pend_src_q;
    src_d      = src_q;
    blk_hold_d = blk_hold_q;
    ff46_d     = ff46_q;
    rd_en_d    = 1'b0;
    idx_load0  = 1'b0;
    idx_inc    = 1'b0;

    if (wr_hit) begin
      state_d    = START;
      dly_d      = DW'(START_DELAY);
      pend_src_d = src_page(cpu_wdata);
      ff46_d     = cpu_wdata;
      // Restarting over a live transfer keeps the bus owned across the gap.
      blk_hold_d = (state_q == XFER) || ((state_q == START) && blk_hold_q);
      rd_en_d    = old_more;
      idx_inc    = old_more;
    end else begin
      unique case (state_q)
        START: begin
          dly_d = dly_q - DW'(1);
          if (dly_q == DW'(1)) begin
            state_d    = XFER;
            src_d      = pend_src_q;
            blk_hold_d = 1'b0;
            rd_en_d    = 1'b1;
            idx_load0  = 1'b1;
          end else begin
            rd_en_d = old_more;
            idx_inc = old_more;
          end
        end
        XFER: begin
          if (idx_tc) begin
            state_d = IDLE;
          end else begin
            rd_en_d = 1'b1;
            idx_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end

    rd_addr_d = rd_en_d ? {src_d, idx_nxt} : 16'h0000;
    // The byte read this cycle is written to OAM in the next one.
    wr_en_d   = rd_en_q;
    wr_addr_d = rd_en_q ? rd_addr_q[7:0] : 8'h00;
    wr_data_d = rd_en_q ? rd_data : 8'h00;
    busy_d    = (state_d != IDLE) || wr_en_d;
    blk_d     = rd_en_d || wr_en_d || ((state_d == START) && blk_hold_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dly_q      <= '0;
      pend_src_q <= 8'h00;
      src_q      <= 8'h00;
      blk_hold_q <= 1'b0;
      ff46_q     <= 8'hFF;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= 16'h0000;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      blk_q      <= 1'b0;
    end else if (mcyc_en) begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      pend_src_q <= pend_src_d;
      src_q      <= src_d;
      blk_hold_q <= blk_hold_d;
      ff46_q     <= ff46_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      blk_q      <= blk_d;
    end
  end

  assign ff46_rdata    = ff46_q;
  assign dma_rd_en     = rd_en_q;
  assign dma_rd_addr   = rd_addr_q;
  assign oam_wr_en     = wr_en_q;
  assign oam_wr_addr   = wr_addr_q;
  assign oam_wr_data   = wr_data_q;
  assign dma_busy      = busy_q;
  assign cpu_bus_block = blk_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_oam_dma_ctrl
// Self-checking bench for oam_dma_ctrl: a transfer-level reference model is
// compared with every DUT output on every clock, plus directed scenarios with
// hand-computed cycle numbers and OAM contents.
// -----------------------------------------------------------------------------
module tb_oam_dma_ctrl;

  localparam int LEN = 160;
  localparam int SD  = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        mcyc_en;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  rd_data;
  logic [7:0]  ff46_rdata;
  logic        dma_rd_en;
  logic [15:0] dma_rd_addr;
  logic        oam_wr_en;
  logic [7:0]  oam_wr_addr;
  logic [7:0]  oam_wr_data;
  logic        dma_busy;
  logic        cpu_bus_block;

  always #5 clk = ~clk;

  oam_dma_ctrl #(
    .LEN         (LEN),
    .START_DELAY (SD),
    .REG_ADDR    (16'hFF46)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mcyc_en       (mcyc_en),
    .cpu_wr        (cpu_wr),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .rd_data       (rd_data),
    .ff46_rdata    (ff46_rdata),
    .dma_rd_en     (dma_rd_en),
    .dma_rd_addr   (dma_rd_addr),
    .oam_wr_en     (oam_wr_en),
    .oam_wr_addr   (oam_wr_addr),
    .oam_wr_data   (oam_wr_data),
    .dma_busy      (dma_busy),
    .cpu_bus_block (cpu_bus_block)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a running transfer (page, byte being read), a pending
  // start request (page, cycles left, whether the bus stays owned), and the
  // byte read last cycle which becomes this cycle's OAM write.
  // ---------------------------------------------------------------------------
  bit         m_xfer_on, m_start_on, m_start_blk;
  int         m_k, m_left;
  logic [7:0] m_xsrc, m_ssrc;

  logic [7:0]  e_ff46 = 8'hFF;
  logic        e_rd_en, e_wr_en, e_busy, e_blk;
  logic [15:0] e_rd_addr;
  logic [7:0]  e_wr_addr, e_wr_data;

  task automatic model_advance();
    m_k++;
    if (m_k == LEN) m_xfer_on = 1'b0;
  endtask

  task automatic model_edge();
    logic       nwr;
    logic [7:0] nwa, nwd, d;
    bit         blk;
    if (reset) begin
      m_xfer_on = 0; m_start_on = 0; m_start_blk = 0; m_k = 0; m_left = 0;
      e_ff46 = 8'hFF; e_rd_en = 0; e_rd_addr = 0; e_wr_en = 0;
      e_wr_addr = 0; e_wr_data = 0; e_busy = 0; e_blk = 0;
    end else if (mcyc_en) begin
      nwr = e_rd_en;
      nwa = e_rd_addr[7:0];
      nwd = rd_data;
      if (cpu_wr && cpu_addr == 16'hFF46) begin
        d   = cpu_wdata;
        blk = m_start_on ? m_start_blk : m_xfer_on;
        m_start_on  = 1'b1;
        m_left      = SD;
        m_ssrc      = (d >= 8'hE0) ? d - 8'h20 : d;  // echo RAM sits 8 KiB up
        m_start_blk = blk;
        e_ff46      = d;
        if (m_xfer_on) model_advance();
      end else if (m_start_on) begin
        m_left--;
        if (m_left == 0) begin
          m_start_on = 1'b0;
          m_xfer_on  = 1'b1;
          m_xsrc     = m_ssrc;
          m_k        = 0;
        end else if (m_xfer_on) begin
          model_advance();
        end
      end else if (m_xfer_on) begin
        model_advance();
      end
      e_rd_en   = m_xfer_on;
      e_rd_addr = m_xfer_on ? {m_xsrc, 8'(m_k)} : 16'h0000;
      e_wr_en   = nwr;
      e_wr_addr = nwr ? nwa : 8'h00;
      e_wr_data = nwr ? nwd : 8'h00;
      e_busy    = m_start_on || m_xfer_on || nwr;
      e_blk     = m_xfer_on || nwr || (m_start_on && m_start_blk);
    end
  endtask

  always @(posedge clk) model_edge();

  // Compare process: every output, every clock, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ff46_rdata",    16'(ff46_rdata),    16'(e_ff46));
      check("dma_rd_en",     16'(dma_rd_en),     16'(e_rd_en));
      check("dma_rd_addr",   dma_rd_addr,        e_rd_addr);
      check("oam_wr_en",     16'(oam_wr_en),     16'(e_wr_en));
      check("oam_wr_addr",   16'(oam_wr_addr),   16'(e_wr_addr));
      check("oam_wr_data",   16'(oam_wr_data),   16'(e_wr_data));
      check("dma_busy",      16'(dma_busy),      16'(e_busy));
      check("cpu_bus_block", 16'(cpu_bus_block), 16'(e_blk));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers and observation of the DUT for the literal checks.
  // ---------------------------------------------------------------------------
  int         rd_mode;  // 0: addr low byte, 1: low ^ high byte, 2: random
  int         mc;
  int         first_rd_cyc, last_wr_cyc, busy_fall, n_rd, n_wr, blk_low, busy_seen;
  logic [15:0] first_rd_addr;
  bit         track_blk;
  logic [7:0] oam_sh [256];
  logic [7:0] first_val [256];
  bit         wrote [256];

  task automatic clear_obs();
    first_rd_cyc = -1; last_wr_cyc = -1; busy_fall = -1; n_rd = 0; n_wr = 0;
    blk_low = 0; busy_seen = 0; first_rd_addr = 16'hxxxx; track_blk = 1'b0; mc = 0;
    for (int i = 0; i < 256; i++) begin
      oam_sh[i] = 8'h00; first_val[i] = 8'h00; wrote[i] = 1'b0;
    end
  endtask

  task automatic drive_rd();
    case (rd_mode)
      0:       rd_data = dma_rd_addr[7:0];
      1:       rd_data = dma_rd_addr[7:0] ^ dma_rd_addr[15:8];
      default: rd_data = 8'($urandom);
    endcase
  endtask

  task automatic observe();
    if (dma_rd_en) begin
      n_rd++;
      if (first_rd_cyc < 0) begin
        first_rd_cyc  = mc;
        first_rd_addr = dma_rd_addr;
      end
    end
    if (oam_wr_en) begin
      n_wr++;
      last_wr_cyc = mc;
      oam_sh[oam_wr_addr] = oam_wr_data;
      if (!wrote[oam_wr_addr]) begin
        first_val[oam_wr_addr] = oam_wr_data;
        wrote[oam_wr_addr]     = 1'b1;
      end
    end
    if (dma_busy) busy_seen++;
    if (busy_fall < 0 && !dma_busy) busy_fall = mc;
    if (track_blk && dma_busy && !cpu_bus_block) blk_low++;
  endtask

  // One M-cycle, optionally preceded by idle clocks carrying an unqualified
  // register write that must be ignored.
  task automatic mcyc(input bit wr, input logic [15:0] a, input logic [7:0] d, input int idle);
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      mcyc_en = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = 8'($urandom);
      @(posedge clk); #1;
      drive_rd();
    end
    @(negedge clk);
    mcyc_en = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    mcyc_en = 1'b0; cpu_wr = 1'b0;
    mc++;
    observe();
    drive_rd();
  endtask

  task automatic run_until_idle(input int idle, input int budget);
    int n = 0;
    while (busy_fall < 0 && n < budget) begin
      mcyc(1'b0, 16'h0000, 8'h00, idle);
      n++;
    end
    check("idle_timeout", 16'(busy_fall < 0), 16'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; mcyc_en = 1'b0; cpu_wr = 1'b0;
    @(posedge clk); #1;
    drive_rd();
    reset = 1'b0;
  endtask

  task automatic basic_test(input int idle);
    int bad = 0;
    rd_mode = 0;
    clear_obs();
    mcyc(1'b1, 16'hFF46, 8'hC1, idle);
    run_until_idle(idle, 400);
    for (int i = 0; i < LEN; i++) if (oam_sh[i] !== 8'(i)) bad++;
    check("basic_first_rd_cyc", 16'(first_rd_cyc), 16'd2);
    check("basic_first_rd_addr", first_rd_addr, 16'hC100);
    check("basic_n_rd", 16'(n_rd), 16'd160);
    check("basic_n_wr", 16'(n_wr), 16'd160);
    check("basic_last_wr_cyc", 16'(last_wr_cyc), 16'd162);
    check("basic_busy_fall", 16'(busy_fall), 16'd163);
    check("basic_ff46", 16'(ff46_rdata), 16'h00C1);
    check("basic_oam_bad", 16'(bad), 16'd0);
  endtask

  initial begin
    int bad;
    int r;
    logic [15:0] a;
    reset = 1'b1; mcyc_en = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    rd_data = 8'h0; rd_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_ff46", 16'(ff46_rdata), 16'h00FF);
    check("rst_busy", 16'(dma_busy), 16'h0);
    check("rst_blk", 16'(cpu_bus_block), 16'h0);
    reset = 1'b0;

    // Basic transfer, then the same with three gated clocks per strobe.
    basic_test(0);
    basic_test(3);

    // Echo-RAM source page.
    clear_obs();
    mcyc(1'b1, 16'hFF46, 8'hE5, 0);
    run_until_idle(0, 400);
    check("echo_first_rd_addr", first_rd_addr, 16'hC500);
    check("echo_ff46", 16'(ff46_rdata), 16'h00E5);

    // Restart during a transfer after 50 reads.
    rd_mode = 1;
    clear_obs();
    mcyc(1'b1, 16'hFF46, 8'hC0, 0);
    for (int n = 0; n < 200 && n_rd < 50; n++) mcyc(1'b0, 16'h0, 8'h0, 0);
    track_blk = 1'b1;
    mcyc(1'b1, 16'hFF46, 8'hD0, 0);
    run_until_idle(0, 400);
    bad = 0;
    for (int i = 0; i < LEN; i++) if (oam_sh[i] !== (8'(i) ^ 8'hD0)) bad++;
    check("rs_first_val0", 16'(first_val[0]), 16'h00C0);
    check("rs_first_val49", 16'(first_val[49]), 16'h00F1);
    check("rs_first_val50", 16'(first_val[50]), 16'h00F2);
    check("rs_first_val51", 16'(first_val[51]), 16'h00E3);
    check("rs_final_oam_bad", 16'(bad), 16'd0);
    check("rs_blk_low", 16'(blk_low), 16'd0);
    check("rs_n_rd", 16'(n_rd), 16'd211);
    check("rs_busy_fall", 16'(busy_fall), 16'd214);

    // Restart inside the START window: nothing copied from the first page.
    rd_mode = 0;
    clear_obs();
    mcyc(1'b1, 16'hFF46, 8'hC1, 0);
    mcyc(1'b1, 16'hFF46, 8'hD2, 0);
    run_until_idle(0, 400);
    check("rss_first_rd_cyc", 16'(first_rd_cyc), 16'd3);
    check("rss_first_rd_addr", first_rd_addr, 16'hD200);
    check("rss_n_wr", 16'(n_wr), 16'd160);
    check("rss_busy_fall", 16'(busy_fall), 16'd164);

    // Reset after 20 reads aborts the copy.
    clear_obs();
    mcyc(1'b1, 16'hFF46, 8'hC1, 0);
    for (int n = 0; n < 100 && n_rd < 20; n++) mcyc(1'b0, 16'h0, 8'h0, 0);
    pulse_reset();
    check("rmid_busy", 16'(dma_busy), 16'h0);
    check("rmid_wr_en", 16'(oam_wr_en), 16'h0);
    check("rmid_ff46", 16'(ff46_rdata), 16'h00FF);
    clear_obs();
    repeat (30) mcyc(1'b0, 16'h0, 8'h0, 0);
    check("rmid_no_writes", 16'(n_wr), 16'd0);
    check("rmid_no_reads", 16'(n_rd), 16'd0);

    // Writes to neighbouring registers do nothing.
    clear_obs();
    mcyc(1'b1, 16'hFF45, 8'hC1, 0);
    mcyc(1'b1, 16'hFF47, 8'hC2, 0);
    repeat (5) mcyc(1'b0, 16'h0, 8'h0, 0);
    check("nreg_busy_seen", 16'(busy_seen), 16'd0);
    check("nreg_ff46", 16'(ff46_rdata), 16'h00FF);

    // Random traffic against the model.
    rd_mode = 2;
    for (int it = 0; it < 3000; it++) begin
      r = $urandom_range(0, 999);
      if (r < 8) begin
        mcyc(1'b1, 16'hFF46, 8'($urandom), $urandom_range(0, 2));
      end else if (r < 10) begin
        pulse_reset();
      end else begin
        a = 16'($urandom);
        if (a == 16'hFF46) a = 16'hFF47;
        mcyc(1'($urandom), a, 8'($urandom), $urandom_range(0, 2));
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
